gt_tx_link_sched: RTL and testbench



---
 rtl/gt_link_pkg.sv | 29 ++
 rtl/gt_cc_timer.sv | 43 ++++
 rtl/gt_tx_link_sched.sv | 171 +++++++++++++++++
 tb/tb_gt_tx_link_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_link_pkg.sv
// Shared definitions for the GT transmit lane.
//   - K-code lane words (32-bit data) and their K-flag masks (4-bit ctrl,
//     bit n flags byte n as a control character).
//   - sched_state_t: state encoding of the lane scheduler FSM.
package gt_link_pkg;

    // Clock-correction word: four K23.7 characters.
    localparam logic [31:0] K_CC         = 32'hf7_f7_f7_f7;
    localparam logic [3:0]  CTRL_CC      = 4'b1111;

    // Alternating idle pair, comma (K28.5) in byte 0.
    localparam logic [31:0] K_IDLE0      = 32'hff_55_55_bc;
    localparam logic [31:0] K_IDLE1      = 32'hff_aa_aa_bc;
    localparam logic [3:0]  CTRL_IDLE    = 4'b0001;

    // Framing words; LINE_END also terminates a force-aborted packet.
    localparam logic [31:0] K_FRAME_SYNC = 32'hff_00_01_bc;
    localparam logic [31:0] K_LINE_START = 32'hff_00_02_bc;
    localparam logic [31:0] K_LINE_END   = 32'hff_00_03_bc;
    localparam logic [3:0]  CTRL_FRAME   = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CC   = 2'd1,
        VID  = 2'd2,
        AUX  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/gt_cc_timer.sv
// Clock-correction period timer.
//   tx_clk     in   lane clock
//   rst        in   asynchronous active-high reset
//   cc_take    in   scheduler is entering its CC sequence this cycle
//   cc_pending out  a CC sequence is owed to the lane
//   cc_miss    out  sticky: a period expired while a CC was still owed
module gt_cc_timer #(
    parameter int CC_PERIOD = 5000,
    parameter int CNT_W     = 16
) (
    input  logic tx_clk,
    input  logic rst,
    input  logic cc_take,
    output logic cc_pending,
    output logic cc_miss
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(CC_PERIOD - 1));

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            cc_pending <= 1'b0;
            cc_miss    <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                // A wrap coinciding with the take re-arms pending without
                // counting as a miss: the old request is being served now.
                cc_pending <= 1'b1;
                if (cc_pending && !cc_take) begin
                    cc_miss <= 1'b1;
                end
            end else if (cc_take) begin
                cc_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gt_tx_link_sched.sv
// GT transmit lane scheduler: shares one 32-bit lane between a video and
// an aux packet requester, inserts clock-correction only between packets,
// and fills the lane with the alternating idle pair otherwise.
//   tx_clk, rst                 clock, asynchronous active-high reset
//   vid_req/data/ctrl/last      video word offer (req held for whole packet)
//   vid_ack                     video word taken when vid_req && vid_ack
//   aux_req/data/ctrl/last/ack  same for the aux/control requester
//   gt_tx_data, gt_tx_ctrl      registered lane word and K-flags
//   cc_miss                     sticky CC overrun flag
//   pkt_abort                   one-cycle pulse on forced packet termination
//
// Handshake: a word transfers on a rising edge where req and ack are both
// high; ack is a pure decode of the state register and never depends on req.
module gt_tx_link_sched
    import gt_link_pkg::*;
#(
    parameter int CC_PERIOD     = 5000,
    parameter int CC_LEN        = 2,
    parameter int MAX_PKT_WORDS = 2048,
    parameter int CNT_W         = 16
) (
    input  logic        tx_clk,
    input  logic        rst,
    input  logic        vid_req,
    input  logic [31:0] vid_data,
    input  logic [3:0]  vid_ctrl,
    input  logic        vid_last,
    output logic        vid_ack,
    input  logic        aux_req,
    input  logic [31:0] aux_data,
    input  logic [3:0]  aux_ctrl,
    input  logic        aux_last,
    output logic        aux_ack,
    output logic [31:0] gt_tx_data,
    output logic [3:0]  gt_tx_ctrl,
    output logic        cc_miss,
    output logic        pkt_abort
);

    sched_state_t     state, state_nxt;
    logic             idle_phase, idle_phase_nxt;
    logic             rr_aux, rr_aux_nxt;       // 1: aux wins a tie
    logic             end_pend, end_pend_nxt;   // LINE_END owed after abort
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic [3:0]       cc_cnt, cc_cnt_nxt;
    logic [31:0]      data_nxt;
    logic [3:0]       ctrl_nxt;
    logic             abort_nxt;
    logic             cc_take;
    logic             cc_pending;

    // Granted requester, muxed once so VID and AUX share one code path.
    logic             g_req;
    logic             g_last;
    logic [31:0]      g_data;
    logic [3:0]       g_ctrl;

    assign g_req  = (state == AUX) ? aux_req  : vid_req;
    assign g_last = (state == AUX) ? aux_last : vid_last;
    assign g_data = (state == AUX) ? aux_data : vid_data;
    assign g_ctrl = (state == AUX) ? aux_ctrl : vid_ctrl;

    assign vid_ack = (state == VID);
    assign aux_ack = (state == AUX);

    gt_cc_timer #(
        .CC_PERIOD (CC_PERIOD),
        .CNT_W     (CNT_W)
    ) u_cc_timer (
        .tx_clk     (tx_clk),
        .rst        (rst),
        .cc_take    (cc_take),
        .cc_pending (cc_pending),
        .cc_miss    (cc_miss)
    );

    always_comb begin
        state_nxt      = state;
        idle_phase_nxt = idle_phase;
        rr_aux_nxt     = rr_aux;
        end_pend_nxt   = 1'b0;
        word_cnt_nxt   = word_cnt;
        cc_cnt_nxt     = cc_cnt;
        data_nxt       = K_IDLE0;
        ctrl_nxt       = CTRL_IDLE;
        abort_nxt      = 1'b0;
        cc_take        = 1'b0;

        case (state)
            IDLE: begin
                word_cnt_nxt = '0;
                cc_cnt_nxt   = '0;
                if (end_pend) begin
                    // Close the aborted packet; arbitration waits one more
                    // cycle so an idle word still precedes the next grant.
                    data_nxt = K_LINE_END;
                    ctrl_nxt = CTRL_FRAME;
                end else begin
                    data_nxt       = idle_phase ? K_IDLE1 : K_IDLE0;
                    idle_phase_nxt = ~idle_phase;
                    if (cc_pending) begin
                        state_nxt = CC;
                        cc_take   = 1'b1;
                    end else if (vid_req && (!aux_req || !rr_aux)) begin
                        state_nxt = VID;
                    end else if (aux_req) begin
                        state_nxt = AUX;
                    end
                end
            end

            CC: begin
                data_nxt = K_CC;
                ctrl_nxt = CTRL_CC;
                if (cc_cnt == 4'(CC_LEN - 1)) begin
                    state_nxt      = IDLE;
                    idle_phase_nxt = 1'b0;
                end else begin
                    cc_cnt_nxt = cc_cnt + 4'd1;
                end
            end

            VID, AUX: begin
                // Underrun keeps the defaults: IDLE0 on the lane, no count.
                if (g_req) begin
                    data_nxt     = g_data;
                    ctrl_nxt     = g_ctrl;
                    word_cnt_nxt = word_cnt + 1'b1;
                    if (g_last) begin
                        state_nxt  = IDLE;
                        rr_aux_nxt = (state == VID);
                    end else if (word_cnt == CNT_W'(MAX_PKT_WORDS - 1)) begin
                        state_nxt    = IDLE;
                        rr_aux_nxt   = (state == VID);
                        abort_nxt    = 1'b1;
                        end_pend_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idle_phase <= 1'b0;
            rr_aux     <= 1'b0;
            end_pend   <= 1'b0;
            word_cnt   <= '0;
            cc_cnt     <= '0;
            gt_tx_data <= '0;
            gt_tx_ctrl <= '0;
            pkt_abort  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idle_phase <= idle_phase_nxt;
            rr_aux     <= rr_aux_nxt;
            end_pend   <= end_pend_nxt;
            word_cnt   <= word_cnt_nxt;
            cc_cnt     <= cc_cnt_nxt;
            gt_tx_data <= data_nxt;
            gt_tx_ctrl <= ctrl_nxt;
            pkt_abort  <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_gt_tx_link_sched.sv
// Directed bench for gt_tx_link_sched. Instance dut uses CC_PERIOD=20 and
// CC_LEN=2; instance dut_abort uses MAX_PKT_WORDS=8 for the abort case.
module tb_gt_tx_link_sched;
    import gt_link_pkg::*;

    logic tx_clk = 1'b0;
    logic rst    = 1'b0;
    always #5 tx_clk = ~tx_clk;

    logic        vid_req, vid_last, vid_ack;
    logic [31:0] vid_data;
    logic [3:0]  vid_ctrl;
    logic        aux_req, aux_last, aux_ack;
    logic [31:0] aux_data;
    logic [3:0]  aux_ctrl;
    logic [31:0] gt_tx_data;
    logic [3:0]  gt_tx_ctrl;
    logic        cc_miss, pkt_abort;

    logic        zero1  = 1'b0;
    logic [31:0] zero32 = '0;
    logic [3:0]  zero4  = '0;
    logic        b_vid_ack, b_aux_ack, b_cc_miss, b_pkt_abort;
    logic [31:0] b_data;
    logic [3:0]  b_ctrl;

    logic [35:0] lane_a, lane_b;
    assign lane_a = {gt_tx_ctrl, gt_tx_data};
    assign lane_b = {b_ctrl, b_data};

    gt_tx_link_sched #(.CC_PERIOD(20), .CC_LEN(2), .MAX_PKT_WORDS(2048), .CNT_W(16)) dut (
        .tx_clk(tx_clk), .rst(rst),
        .vid_req(vid_req), .vid_data(vid_data), .vid_ctrl(vid_ctrl), .vid_last(vid_last), .vid_ack(vid_ack),
        .aux_req(aux_req), .aux_data(aux_data), .aux_ctrl(aux_ctrl), .aux_last(aux_last), .aux_ack(aux_ack),
        .gt_tx_data(gt_tx_data), .gt_tx_ctrl(gt_tx_ctrl), .cc_miss(cc_miss), .pkt_abort(pkt_abort)
    );

    gt_tx_link_sched #(.CC_PERIOD(5000), .CC_LEN(2), .MAX_PKT_WORDS(8), .CNT_W(16)) dut_abort (
        .tx_clk(tx_clk), .rst(rst),
        .vid_req(zero1), .vid_data(zero32), .vid_ctrl(zero4), .vid_last(zero1), .vid_ack(b_vid_ack),
        .aux_req(aux_req), .aux_data(aux_data), .aux_ctrl(aux_ctrl), .aux_last(aux_last), .aux_ack(b_aux_ack),
        .gt_tx_data(b_data), .gt_tx_ctrl(b_ctrl), .cc_miss(b_cc_miss), .pkt_abort(b_pkt_abort)
    );

    // Source queues hold {last, ctrl, data}; expected lane words {ctrl, data}.
    logic [36:0] vid_q[$];
    logic [36:0] aux_q[$];
    logic [35:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sel_b    = 1'b0;

    localparam logic [35:0] W_I0 = {CTRL_IDLE, K_IDLE0};
    localparam logic [35:0] W_I1 = {CTRL_IDLE, K_IDLE1};
    localparam logic [35:0] W_CC = {CTRL_CC, K_CC};
    localparam logic [35:0] W_LE = {CTRL_FRAME, K_LINE_END};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_lane(input string tag, input logic [35:0] obs);
        logic [35:0] e;
        e = exp_q.pop_front();
        check(tag, {28'd0, obs}, {28'd0, e});
    endtask

    task automatic drive();
        if (vid_q.size() > 0) begin
            vid_req = 1'b1;
            {vid_last, vid_ctrl, vid_data} = vid_q[0];
        end else begin
            vid_req = 1'b0; vid_last = 1'b0; vid_ctrl = '0; vid_data = '0;
        end
        if (aux_q.size() > 0) begin
            aux_req = 1'b1;
            {aux_last, aux_ctrl, aux_data} = aux_q[0];
        end else begin
            aux_req = 1'b0; aux_last = 1'b0; aux_ctrl = '0; aux_data = '0;
        end
    endtask

    // One clock: words offered with ack high are consumed at the edge;
    // outputs are then sampled 1 time unit after the edge.
    task automatic cycle();
        logic v_acc, a_acc;
        v_acc = vid_req && vid_ack;
        a_acc = aux_req && (sel_b ? b_aux_ack : aux_ack);
        @(posedge tx_clk);
        #1;
        if (v_acc) void'(vid_q.pop_front());
        if (a_acc) void'(aux_q.pop_front());
        if (sel_b && b_pkt_abort) aux_q.delete();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vid_q.delete(); aux_q.delete(); exp_q.delete();
        drive();
        #1;
        check("rst_lane", {28'd0, lane_a}, 64'd0);
        check("rst_acks", {62'd0, vid_ack, aux_ack}, 64'd0);
        check("rst_flags", {62'd0, cc_miss, pkt_abort}, 64'd0);
        check("rst_lane_b", {28'd0, lane_b}, 64'd0);
        @(posedge tx_clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    initial begin
        logic [6:0]  ack_pat;
        int          n_ack, n_abort;

        #2;
        // Test 1: idle fill after reset, starting with the 55 word.
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? W_I0 : W_I1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_lane("t1_idle", lane_a);
        end

        // Test 2: 4-word video packet, latency 1, one idle after.
        do_reset();
        vid_q.push_back({1'b0, 4'h0, 32'h11111111});
        vid_q.push_back({1'b0, 4'h0, 32'h22222222});
        vid_q.push_back({1'b0, 4'h0, 32'h33333333});
        vid_q.push_back({1'b1, 4'h0, 32'h44444444});
        drive();
        exp_q = '{W_I0, {4'h0, 32'h11111111}, {4'h0, 32'h22222222}, {4'h0, 32'h33333333},
                  {4'h0, 32'h44444444}, W_I1, W_I0};
        ack_pat = 7'b0001111;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check_lane("t2_lane", lane_a);
            check("t2_vid_ack", {63'd0, vid_ack}, {63'd0, ack_pat[i]});
        end

        // Test 3: both requesters, two 2-word packets each -> V, A, V, A.
        do_reset();
        vid_q.push_back({1'b0, 4'h0, 32'hb0000001});
        vid_q.push_back({1'b1, 4'h0, 32'hb0000002});
        vid_q.push_back({1'b0, 4'h0, 32'hb0000003});
        vid_q.push_back({1'b1, 4'h0, 32'hb0000004});
        aux_q.push_back({1'b0, 4'h8, 32'hc0000001});
        aux_q.push_back({1'b1, 4'h8, 32'hc0000002});
        aux_q.push_back({1'b0, 4'h8, 32'hc0000003});
        aux_q.push_back({1'b1, 4'h8, 32'hc0000004});
        drive();
        exp_q = '{W_I0, {4'h0, 32'hb0000001}, {4'h0, 32'hb0000002},
                  W_I1, {4'h8, 32'hc0000001}, {4'h8, 32'hc0000002},
                  W_I0, {4'h0, 32'hb0000003}, {4'h0, 32'hb0000004},
                  W_I1, {4'h8, 32'hc0000003}, {4'h8, 32'hc0000004},
                  W_I0, W_I1};
        for (int i = 0; i < 14; i++) begin
            cycle();
            check_lane("t3_rr_lane", lane_a);
        end

        // Test 4: 30-word packet spanning two CC wraps (edges 20 and 40).
        do_reset();
        for (int k = 1; k <= 46; k++) begin
            if (k <= 10)       exp_q.push_back((k % 2 == 1) ? W_I0 : W_I1);
            else if (k == 11)  exp_q.push_back(W_I0);
            else if (k <= 41)  exp_q.push_back({4'h0, 32'h10000000 + 32'(k - 11)});
            else if (k == 42)  exp_q.push_back(W_I1);
            else if (k <= 44)  exp_q.push_back(W_CC);
            else if (k == 45)  exp_q.push_back(W_I0);
            else               exp_q.push_back(W_I1);
        end
        for (int k = 1; k <= 46; k++) begin
            cycle();
            check_lane("t4_cc_lane", lane_a);
            if (k == 10) begin
                for (int w = 1; w <= 30; w++)
                    vid_q.push_back({(w == 30), 4'h0, 32'h10000000 + 32'(w)});
                drive();
            end
            if (k == 39) check("t4_miss_early", {63'd0, cc_miss}, 64'd0);
            if (k == 41) check("t4_miss", {63'd0, cc_miss}, 64'd1);
        end

        // Test 5: MAX_PKT_WORDS=8 instance, aux streams 10 words without last.
        do_reset();
        sel_b = 1'b1;
        for (int w = 1; w <= 10; w++) aux_q.push_back({1'b0, 4'h0, 32'ha0000000 + 32'(w)});
        drive();
        exp_q.push_back(W_I0);
        for (int w = 1; w <= 8; w++) exp_q.push_back({4'h0, 32'ha0000000 + 32'(w)});
        exp_q.push_back(W_LE);
        exp_q.push_back(W_I1);
        exp_q.push_back(W_I0);
        n_ack = 0;
        n_abort = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check_lane("t5_abort_lane", lane_b);
            if (b_aux_ack) n_ack++;
            if (b_pkt_abort) n_abort++;
            if (k == 9) check("t5_abort_pulse", {63'd0, b_pkt_abort}, 64'd1);
        end
        check("t5_acks", 64'(n_ack), 64'd8);
        check("t5_abort_count", 64'(n_abort), 64'd1);
        sel_b = 1'b0;

        // Test 6: async reset mid video packet, then idle and CC restart.
        do_reset();
        for (int w = 1; w <= 6; w++) vid_q.push_back({(w == 6), 4'h0, 32'hd0000000 + 32'(w)});
        drive();
        exp_q = '{W_I0, {4'h0, 32'hd0000001}, {4'h0, 32'hd0000002}};
        for (int k = 1; k <= 3; k++) begin
            cycle();
            check_lane("t6_pre_lane", lane_a);
        end
        rst = 1'b1;
        #1;
        check("t6_rst_lane", {28'd0, lane_a}, 64'd0);
        check("t6_rst_acks", {62'd0, vid_ack, aux_ack}, 64'd0);
        vid_q.delete();
        drive();
        @(posedge tx_clk);
        #1;
        rst = 1'b0;
        drive();
        for (int k = 1; k <= 23; k++) begin
            if (k <= 21) exp_q.push_back((k % 2 == 1) ? W_I0 : W_I1);
            else         exp_q.push_back(W_CC);
        end
        for (int k = 1; k <= 23; k++) begin
            cycle();
            check_lane("t6_post_lane", lane_a);
        end
        check("t6_miss", {63'd0, cc_miss}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
